// File: rtl/calib_pkg.sv
// calib_pkg: shared constants, FSM states and {X,Y} entry helpers for the calibration LUT
package calib_pkg;
  localparam int CALIB_M = 16;
  localparam int CALIB_N = 16;
  localparam int CALIB_DEPTH = 16;
  localparam int CALIB_AW = 4;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} calib_state_t;
  function automatic logic [CALIB_M+CALIB_N-1:0] calib_pack(input logic [CALIB_M-1:0] x, input logic [CALIB_N-1:0] y);
    return {x, y};
  endfunction
  function automatic logic [CALIB_M-1:0] calib_x(input logic [CALIB_M+CALIB_N-1:0] e);
    return e[CALIB_M+CALIB_N-1:CALIB_N];
  endfunction
  function automatic logic [CALIB_N-1:0] calib_y(input logic [CALIB_M+CALIB_N-1:0] e);
    return e[CALIB_N-1:0];
  endfunction
endpackage

// File: rtl/calib_lut_ram.sv
// calib_lut_ram: DEPTH x W table, one sync write port, one sync read-before-write read port
module calib_lut_ram #(
  parameter int W = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];
  // storage write; contents survive reset
  always_ff @(posedge clock)
    if (we) mem[wa] <= wd;
  // registered read sees the pre-write contents on an address collision
  always_ff @(posedge clock)
    rd <= reset ? '0 : mem[ra];
endmodule

// File: rtl/calib_lut_loader.sv
// calib_lut_loader: streams DEPTH monotonic (X,Y) pairs into the calibration LUT and serves reads
module calib_lut_loader import calib_pkg::*; #(
  parameter int M = CALIB_M,
  parameter int N = CALIB_N,
  parameter int DEPTH = CALIB_DEPTH,
  parameter int AW = CALIB_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_load,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_x,
  input  logic [N-1:0]  in_y,
  output logic          table_valid,
  output logic          done,
  output logic          error,
  output logic [AW:0]   count,
  input  logic [AW-1:0] rd_addr,
  output logic [M+N-1:0] rd_data
);
  calib_state_t state, state_n;
  logic [M-1:0] last_x;
  logic accept, mono, we, last, clr;
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  // next state and handshake decode
  always_comb begin
    in_ready = state == LOAD && !start_load;
    accept = in_valid && in_ready;
    mono = count == '0 || $signed(in_x) > $signed(last_x);
    we = accept && mono;
    last = count == (AW+1)'(DEPTH-1);
    done = state == DONE;
    clr = start_load && state != DONE;
    state_n = state == IDLE ? (start_load ? LOAD : IDLE) :
              state == DONE ? IDLE :
              start_load ? LOAD :
              accept && !mono ? IDLE :
              we && last ? DONE : LOAD;
  end
  // load bookkeeping: pair count, last X, sticky error and table validity
  always_ff @(posedge clock)
    if (reset) begin
      count <= '0;
      last_x <= '0;
      error <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
        error <= 1'b0;
        table_valid <= 1'b0;
      end
      if (we) begin
        last_x <= in_x;
        count <= count + 1'b1;
      end
      if (accept && !mono) error <= 1'b1;
      if (done) table_valid <= 1'b1;
    end
  calib_lut_ram #(.W(M+N), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock(clock),
    .reset(reset),
    .we(we),
    .wa(count[AW-1:0]),
    .wd({in_x, in_y}),
    .ra(rd_addr),
    .rd(rd_data)
  );
endmodule

// File: tb/tb_calib_lut_loader.sv
// tb_calib_lut_loader: directed checks of load, error, backpressure, restart, reset and read collision
module tb_calib_lut_loader;
  import calib_pkg::*;
  logic clock = 0, reset = 1, start_load = 0, in_valid = 0;
  logic [15:0] in_x = 0, in_y = 0;
  logic [3:0] rd_addr = 0;
  logic in_ready, table_valid, done, error;
  logic [4:0] count;
  logic [31:0] rd_data;
  int total = 0, passed = 0;
  calib_lut_loader dut (
    .clock(clock), .reset(reset), .start_load(start_load), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .table_valid(table_valid),
    .done(done), .error(error), .count(count), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] pa(input int i);
    return calib_pack(16'(-8000 + 1000*i), 16'(-4000 + 500*i));
  endfunction
  function automatic logic [31:0] pb(input int i);
    return calib_pack(16'(-16000 + 2000*i), 16'(i));
  endfunction
  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_x = calib_x(d);
    in_y = calib_y(d);
  endtask
  task automatic pulse_start;
    start_load = 1;
    tick;
    start_load = 0;
  endtask
  initial begin
    int rc;
    logic dn;
    in_valid = 1;
    tick; tick;
    chk("rst_tv", table_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", count, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_rdy_ignored", in_ready, 0);
    reset = 0;
    in_valid = 0;
    tick;
    pulse_start;
    rc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, pa(i));
      #1;
      if (in_ready) rc++;
      if (i == 15) chk("full_no_early_done", done, 0);
      tick;
    end
    drive(0, 0);
    chk("full_ready_cycles", rc, 16);
    chk("full_done", done, 1);
    chk("full_rdy_in_done", in_ready, 0);
    chk("full_cnt", count, 16);
    rd_addr = 3;
    tick;
    chk("full_tv", table_valid, 1);
    chk("full_done_1cyc", done, 0);
    chk("full_rd3", rd_data, {16'(-5000), 16'(-2500)});
    pulse_start;
    chk("err_tv_cleared", table_valid, 0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, pa(i));
      tick;
      dn |= done;
    end
    drive(1, calib_pack(calib_x(pa(3)), 16'h1234));
    tick;
    dn |= done;
    drive(0, 0);
    chk("err_flag", error, 1);
    chk("err_cnt", count, 4);
    chk("err_rdy", in_ready, 0);
    rd_addr = 4;
    tick;
    dn |= done;
    tick;
    dn |= done;
    chk("err_tv", table_valid, 0);
    chk("err_no_done", dn, 0);
    chk("err_sticky", error, 1);
    chk("err_mem4", rd_data, pa(4));
    pulse_start;
    chk("bp_err_clr", error, 0);
    chk("bp_cnt0", count, 0);
    rd_addr = 2;
    for (int c = 0; c < 32; c++) begin
      drive(c % 2 == 0, pb(c / 2));
      tick;
      if (c == 1) chk("bp_cnt_c1", count, 1);
      if (c == 2) chk("bp_cnt_c2", count, 2);
      if (c == 4) chk("rdw_old", rd_data, pa(2));
      if (c == 5) chk("rdw_new", rd_data, pb(2));
    end
    drive(0, 0);
    chk("bp_cnt_final", count, 16);
    chk("bp_tv", table_valid, 1);
    pulse_start;
    for (int i = 0; i < 7; i++) begin
      drive(1, pa(i));
      tick;
    end
    chk("rs_cnt7", count, 7);
    start_load = 1;
    drive(1, pa(7));
    #1;
    chk("rs_rdy_blocked", in_ready, 0);
    tick;
    start_load = 0;
    chk("rs_cnt0", count, 0);
    chk("rs_err", error, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, pa(i));
      tick;
    end
    drive(0, 0);
    chk("rs_done", done, 1);
    tick;
    chk("rs_tv", table_valid, 1);
    chk("rs_cnt16", count, 16);
    pulse_start;
    for (int i = 0; i < 10; i++) begin
      drive(1, pb(i));
      tick;
    end
    chk("rm_cnt10", count, 10);
    reset = 1;
    rd_addr = 5;
    tick;
    reset = 0;
    chk("rm_cnt", count, 0);
    chk("rm_tv", table_valid, 0);
    chk("rm_err", error, 0);
    chk("rm_done", done, 0);
    chk("rm_rdy", in_ready, 0);
    chk("rm_rd", rd_data, 0);
    tick;
    tick;
    chk("rm_tv_held", table_valid, 0);
    chk("rm_mem5_kept", rd_data, pb(5));
    drive(0, 0);
    pulse_start;
    for (int i = 0; i < 16; i++) begin
      drive(1, pa(i));
      tick;
    end
    drive(0, 0);
    tick;
    chk("rm_reload_tv", table_valid, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
